botoes_entrada: RTL and testbench

- Player-input front end for the memory/LED-matrix puzzle. It is the input-side counterpart of the matrix display path.
- Takes the 8 raw push-buttons, then synchronises, debounces and validates a single press-and-release.
- Delivers one encoded move to the control unit through a valid/consumed handshake.
- Also exposes the debounced button levels for the HEX debug display.

---
 rtl/botoes_entrada_pkg.sv | 24 ++
 rtl/botoes_entrada_debounce_bit.sv | 63 ++++++
 rtl/botoes_entrada.sv | 139 +++++++++++++
 tb/tb_botoes_entrada.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/botoes_entrada_pkg.sv
// Shared definitions for the player-input front end: FSM state encoding,
// default button count and the width helper used for codes and counters.
package botoes_pkg;

    // Default number of buttons on the game board (power of two).
    localparam int N_BOTOES_PADRAO = 8;

    // Gesture FSM states, visible on db_estado for the HEX debug display.
    typedef enum logic [1:0] {
        LIVRE     = 2'd0,  // idle, waiting for a press
        SEGURANDO = 2'd1,  // at least one button held, gesture in progress
        PRONTO    = 2'd2,  // move available, waiting for the control unit
        BLOQUEADO = 2'd3   // acknowledged while held; wait for full release
    } estado_t;

    // Bits needed to hold values 0..valor-1, never less than one bit.
    function automatic int largura(input int valor);
        if (valor <= 2) begin
            return 1;
        end
        return $clog2(valor);
    endfunction

endpackage

// File: rtl/botoes_entrada_debounce_bit.sv
// One-bit button conditioner: 2-FF synchroniser followed by a stability
// counter that only lets a level through once it has held for
// DEBOUNCE_CICLOS consecutive synchronised cycles.
module debounce_bit
    import botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic bruto,
    output logic nivel
);

    localparam int              CW      = largura(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic          sinc1_q;
    logic          sinc2_q;
    logic          nivel_q;
    logic          nivel_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two flops bring the asynchronous button into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1_q <= 1'b0;
            sinc2_q <= 1'b0;
        end else begin
            sinc1_q <= bruto;
            sinc2_q <= sinc1_q;
        end
    end

    // Count cycles of disagreement; any agreement restarts the count, so
    // short glitches never flip the debounced level.
    always_comb begin
        nivel_d = nivel_q;
        cnt_d   = '0;
        if (sinc2_q != nivel_q) begin
            if (cnt_q == CNT_MAX) begin
                nivel_d = ~nivel_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register the counter and the debounced level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            nivel_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            nivel_q <= nivel_d;
        end
    end

    assign nivel = nivel_q;

endmodule

// File: rtl/botoes_entrada.sv
// Player-input front end for the memory/LED-matrix puzzle: debounces the
// buttons, validates a single press-and-release gesture and hands one
// encoded move to the control unit via a valid/consumed handshake.
module botoes_entrada
    import botoes_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_BOTOES-1:0]           botoes,
    input  logic                          consumido,
    output logic                          jogada_valida,
    output logic [largura(N_BOTOES)-1:0]  jogada_codigo,
    output logic [N_BOTOES-1:0]           jogada_vetor,
    output logic                          erro_multiplo,
    output logic [N_BOTOES-1:0]           db_botoes,
    output logic [1:0]                    db_estado
);

    localparam int CODW = largura(N_BOTOES);
    localparam int QW   = largura(N_BOTOES + 1);

    logic [N_BOTOES-1:0] db_nivel;
    logic [QW-1:0]       qtd;
    logic [CODW-1:0]     indice;

    estado_t             estado_q;
    logic                multiplo_q;
    logic [CODW-1:0]     idx_q;
    logic [N_BOTOES-1:0] onehot_q;
    logic                valida_q;
    logic [CODW-1:0]     codigo_q;
    logic [N_BOTOES-1:0] vetor_q;
    logic                erro_q;

    // One independent conditioner per button.
    generate
        for (genvar gi = 0; gi < N_BOTOES; gi++) begin : g_debounce
            debounce_bit #(
                .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
            ) u_debounce (
                .clock(clock),
                .reset(reset),
                .bruto(botoes[gi]),
                .nivel(db_nivel[gi])
            );
        end
    endgenerate

    // Number of buttons currently held (debounced).
    always_comb begin
        qtd = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            qtd = qtd + QW'(db_nivel[i]);
        end
    end

    // Index of the held button; only meaningful when exactly one is held.
    always_comb begin
        indice = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (db_nivel[i]) begin
                indice = CODW'(i);
            end
        end
    end

    // Gesture FSM with registered move, error pulse and state outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= LIVRE;
            multiplo_q <= 1'b0;
            idx_q      <= '0;
            onehot_q   <= '0;
            valida_q   <= 1'b0;
            codigo_q   <= '0;
            vetor_q    <= '0;
            erro_q     <= 1'b0;
        end else begin
            erro_q <= 1'b0;
            case (estado_q)
                LIVRE: begin
                    if (qtd == QW'(1)) begin
                        estado_q   <= SEGURANDO;
                        idx_q      <= indice;
                        onehot_q   <= db_nivel;
                        multiplo_q <= 1'b0;
                    end else if (qtd >= QW'(2)) begin
                        estado_q   <= SEGURANDO;
                        multiplo_q <= 1'b1;
                    end
                end
                SEGURANDO: begin
                    if (qtd >= QW'(2)) begin
                        multiplo_q <= 1'b1;
                    end else if (qtd == '0) begin
                        if (multiplo_q) begin
                            // Chord detected at some point: drop the gesture.
                            estado_q <= LIVRE;
                            erro_q   <= 1'b1;
                        end else begin
                            estado_q <= PRONTO;
                            valida_q <= 1'b1;
                            codigo_q <= idx_q;
                            vetor_q  <= onehot_q;
                        end
                    end
                end
                PRONTO: begin
                    // Presses here are ignored; only the acknowledge matters.
                    if (consumido) begin
                        valida_q <= 1'b0;
                        codigo_q <= '0;
                        vetor_q  <= '0;
                        estado_q <= (qtd == '0) ? LIVRE : BLOQUEADO;
                    end
                end
                BLOQUEADO: begin
                    if (qtd == '0) begin
                        estado_q <= LIVRE;
                    end
                end
                default: begin
                    estado_q <= LIVRE;
                end
            endcase
        end
    end

    assign jogada_valida = valida_q;
    assign jogada_codigo = codigo_q;
    assign jogada_vetor  = vetor_q;
    assign erro_multiplo = erro_q;
    assign db_botoes     = db_nivel;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_botoes_entrada.sv
// Directed bench for botoes_entrada with a short debounce window.
module tb_botoes_entrada;

    logic       clock;
    logic       reset;
    logic [7:0] botoes;
    logic       consumido;
    logic       jogada_valida;
    logic [2:0] jogada_codigo;
    logic [7:0] jogada_vetor;
    logic       erro_multiplo;
    logic [7:0] db_botoes;
    logic [1:0] db_estado;

    int total = 0;
    int bad   = 0;

    botoes_entrada #(
        .N_BOTOES(8),
        .DEBOUNCE_CICLOS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .botoes(botoes),
        .consumido(consumido),
        .jogada_valida(jogada_valida),
        .jogada_codigo(jogada_codigo),
        .jogada_vetor(jogada_vetor),
        .erro_multiplo(erro_multiplo),
        .db_botoes(db_botoes),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    // Advance n cycles; called from a falling edge, lands on a falling edge.
    task automatic passo(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Press a button pattern long enough to debounce, release, and wait
    // until the move would be presented.
    task automatic faz_jogada(input logic [7:0] valor);
        botoes = valor;
        passo(10);
        botoes = 8'h00;
        passo(7);
    endtask

    logic       sujo;
    logic       instavel;

    initial begin
        reset     = 1'b0;
        botoes    = 8'h00;
        consumido = 1'b0;
        passo(3);
        checa("rst_valid", 32'(jogada_valida), 32'h0);
        checa("rst_estado", 32'(db_estado), 32'h0);
        checa("rst_db", 32'(db_botoes), 32'h0);
        checa("rst_erro", 32'(erro_multiplo), 32'h0);
        #2 reset = 1'b1;
        passo(2);

        // Single press of button 2.
        botoes = 8'h04;
        passo(5);
        checa("simples_db_e5", 32'(db_botoes), 32'h00);
        passo(1);
        checa("simples_db_e6", 32'(db_botoes), 32'h04);
        checa("simples_estado_e6", 32'(db_estado), 32'h0);
        passo(1);
        checa("simples_estado_seg", 32'(db_estado), 32'h1);
        passo(13);
        botoes = 8'h00;
        passo(6);
        checa("simples_db_zero", 32'(db_botoes), 32'h00);
        checa("simples_valid_cedo", 32'(jogada_valida), 32'h0);
        passo(1);
        checa("simples_valid", 32'(jogada_valida), 32'h1);
        checa("simples_codigo", 32'(jogada_codigo), 32'h2);
        checa("simples_vetor", 32'(jogada_vetor), 32'h04);
        checa("simples_estado_pronto", 32'(db_estado), 32'h2);
        consumido = 1'b1;
        passo(1);
        consumido = 1'b0;
        checa("simples_valid_ack", 32'(jogada_valida), 32'h0);
        checa("simples_codigo_ack", 32'(jogada_codigo), 32'h0);
        checa("simples_estado_ack", 32'(db_estado), 32'h0);
        $display("single press: code=2 delivered and acknowledged");

        // Bounce shorter than the window never reaches the outputs.
        sujo = 1'b0;
        for (int c = 0; c < 22; c++) begin
            botoes = (c < 12 && ((c / 2) % 2 == 0)) ? 8'h01 : 8'h00;
            passo(1);
            if (db_botoes != 8'h00 || jogada_valida || erro_multiplo) sujo = 1'b1;
        end
        checa("bounce_limpo", 32'(sujo), 32'h0);
        checa("bounce_estado", 32'(db_estado), 32'h0);
        $display("bounce: 2-cycle toggles filtered");

        // Chord: 0x10 then 0x30, release both -> single error pulse.
        botoes = 8'h10;
        passo(10);
        checa("multi_estado_seg", 32'(db_estado), 32'h1);
        botoes = 8'h30;
        passo(10);
        checa("multi_db", 32'(db_botoes), 32'h30);
        botoes = 8'h00;
        passo(6);
        checa("multi_db_zero", 32'(db_botoes), 32'h00);
        checa("multi_erro_cedo", 32'(erro_multiplo), 32'h0);
        passo(1);
        checa("multi_erro", 32'(erro_multiplo), 32'h1);
        checa("multi_valid", 32'(jogada_valida), 32'h0);
        checa("multi_estado_livre", 32'(db_estado), 32'h0);
        passo(1);
        checa("multi_erro_fim", 32'(erro_multiplo), 32'h0);
        checa("multi_valid_fim", 32'(jogada_valida), 32'h0);
        $display("multiple: chord discarded with one error pulse");

        // Button held across the acknowledge.
        faz_jogada(8'h80);
        checa("bloq_valid", 32'(jogada_valida), 32'h1);
        checa("bloq_codigo", 32'(jogada_codigo), 32'h7);
        botoes = 8'h80;
        passo(8);
        checa("bloq_db_preso", 32'(db_botoes), 32'h80);
        checa("bloq_estado_pronto", 32'(db_estado), 32'h2);
        checa("bloq_codigo_estavel", 32'(jogada_codigo), 32'h7);
        consumido = 1'b1;
        passo(1);
        consumido = 1'b0;
        checa("bloq_valid_ack", 32'(jogada_valida), 32'h0);
        checa("bloq_estado", 32'(db_estado), 32'h3);
        botoes = 8'h00;
        passo(6);
        checa("bloq_estado_solto", 32'(db_estado), 32'h3);
        passo(1);
        checa("bloq_estado_livre", 32'(db_estado), 32'h0);
        passo(3);
        checa("bloq_sem_nova", 32'(jogada_valida), 32'h0);
        $display("held across ack: blocked, no second move");

        // Long wait for the acknowledge, then a stray acknowledge in LIVRE.
        faz_jogada(8'h08);
        instavel = 1'b0;
        for (int c = 0; c < 50; c++) begin
            passo(1);
            if (jogada_valida !== 1'b1 || jogada_codigo !== 3'd3 || jogada_vetor !== 8'h08) instavel = 1'b1;
        end
        checa("espera_estavel", 32'(instavel), 32'h0);
        consumido = 1'b1;
        passo(1);
        checa("espera_valid_ack", 32'(jogada_valida), 32'h0);
        passo(3);
        checa("espera_ack_livre_estado", 32'(db_estado), 32'h0);
        checa("espera_ack_livre_valid", 32'(jogada_valida), 32'h0);
        consumido = 1'b0;
        $display("ack latency: code=3 held for 50 cycles");

        // Asynchronous reset in the middle of a gesture.
        botoes = 8'h02;
        passo(8);
        checa("rst_seg_estado", 32'(db_estado), 32'h1);
        #2 reset = 1'b0;
        #1;
        checa("rst_seg_estado0", 32'(db_estado), 32'h0);
        checa("rst_seg_db0", 32'(db_botoes), 32'h00);
        botoes = 8'h00;
        #4 reset = 1'b1;
        passo(15);
        checa("rst_seg_sem_jogada", 32'(jogada_valida), 32'h0);
        checa("rst_seg_erro", 32'(erro_multiplo), 32'h0);

        // Asynchronous reset while a move is pending.
        faz_jogada(8'h40);
        checa("rst_pr_valid", 32'(jogada_valida), 32'h1);
        checa("rst_pr_codigo", 32'(jogada_codigo), 32'h6);
        #2 reset = 1'b0;
        #1;
        checa("rst_pr_valid0", 32'(jogada_valida), 32'h0);
        checa("rst_pr_codigo0", 32'(jogada_codigo), 32'h0);
        checa("rst_pr_vetor0", 32'(jogada_vetor), 32'h00);
        checa("rst_pr_estado0", 32'(db_estado), 32'h0);
        #4 reset = 1'b1;
        passo(15);
        checa("rst_pr_sem_jogada", 32'(jogada_valida), 32'h0);
        checa("rst_pr_estado", 32'(db_estado), 32'h0);
        $display("async reset: pending gesture and move discarded");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
